// File: rtl/shift_register_pkg.sv
// Shared types for the SPI-side shift register: default width and the
// per-cycle operation decode used by the register update.
package shift_register_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_RESET = 2'd3
  } shift_op_t;

  // Reset beats load, load beats the strobe; a load with a coincident strobe never shifts.
  function automatic shift_op_t decode_op(input logic reset, input logic load, input logic strobe);
    if (reset) return OP_RESET;
    if (load) return OP_LOAD;
    if (strobe) return OP_SHIFT;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/shift_register_if.sv
// Fabric-side bundle of the shift register: load/strobe controls, data in, data out.
interface shift_register_if #(
  parameter int width = shift_register_pkg::DEFAULT_WIDTH
);
  logic             peripheralClkEdge;
  logic             parallelLoad;
  logic [width-1:0] parallelDataIn;
  logic             serialDataIn;
  logic [width-1:0] parallelDataOut;
  logic             serialDataOut;

  modport master (
    output peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn,
    input  parallelDataOut, serialDataOut
  );

  modport slave (
    input  peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn,
    output parallelDataOut, serialDataOut
  );
endinterface

// File: rtl/shift_register.sv
// SIPO/PISO shift register on clk; shifts right (new bit into MSB) on each
// peripheral-clock edge strobe, serial output is always the current LSB.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int               width       = DEFAULT_WIDTH,
  parameter logic [width-1:0] RESET_VALUE = '0
) (
  input logic          clk,
  input logic          reset,
  shift_register_if.slave bus
);

  logic [width-1:0] mem;
  shift_op_t        op;

  always_comb begin
    op = decode_op(reset, bus.parallelLoad, bus.peripheralClkEdge);
  end

  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: mem <= RESET_VALUE;
      OP_LOAD:  mem <= bus.parallelDataIn;
      OP_SHIFT: mem <= {bus.serialDataIn, mem[width-1:1]};
      default:  mem <= mem;
    endcase
  end

  // Outputs come only from the register, never straight from the inputs.
  assign bus.parallelDataOut = mem;
  assign bus.serialDataOut   = mem[0];

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: 8-bit and 16-bit instances against an arithmetic
// model checked every cycle, plus hand-computed literal points.
module tb_shift_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  shift_register_if #(.width(8))  b8();
  shift_register_if #(.width(16)) b16();

  localparam logic [7:0]  RV8  = 8'h00;
  localparam logic [15:0] RV16 = 16'h8001;

  shift_register #(.width(8), .RESET_VALUE(RV8)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave)
  );
  shift_register #(.width(16), .RESET_VALUE(RV16)) dut16 (
    .clk(clk), .reset(reset), .bus(b16.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: value as a number; a shift halves it and adds the serial bit at weight 2^(w-1).
  logic [7:0]  m8;
  logic [15:0] m16;
  bit          mv = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m8  = RV8;
      m16 = RV16;
      mv  = 1'b1;
    end else begin
      if (b8.parallelLoad) m8 = b8.parallelDataIn;
      else if (b8.peripheralClkEdge) m8 = (m8 / 2) + (b8.serialDataIn ? 8'd128 : 8'd0);
      if (b16.parallelLoad) m16 = b16.parallelDataIn;
      else if (b16.peripheralClkEdge) m16 = (m16 / 2) + (b16.serialDataIn ? 16'd32768 : 16'd0);
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      check("cyc_par8",  {24'd0, b8.parallelDataOut},  {24'd0, m8});
      check("cyc_ser8",  {31'd0, b8.serialDataOut},    {31'd0, m8[0]});
      check("cyc_par16", {16'd0, b16.parallelDataOut}, {16'd0, m16});
      check("cyc_ser16", {31'd0, b16.serialDataOut},   {31'd0, m16[0]});
    end
  end

  task automatic idle_inputs();
    reset = 1'b0;
    b8.parallelLoad = 1'b0;  b8.peripheralClkEdge = 1'b0;
    b16.parallelLoad = 1'b0; b16.peripheralClkEdge = 1'b0;
  endtask

  task automatic s8(input logic rs, input logic ld, input logic st,
                    input logic [7:0] d, input logic si);
    reset = rs;
    b8.parallelLoad = ld; b8.peripheralClkEdge = st;
    b8.parallelDataIn = d; b8.serialDataIn = si;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic s16(input logic ld, input logic st, input logic [15:0] d, input logic si);
    b16.parallelLoad = ld; b16.peripheralClkEdge = st;
    b16.parallelDataIn = d; b16.serialDataIn = si;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic lit8(input string name, input logic [7:0] exp);
    check({name, "_par"},   {24'd0, b8.parallelDataOut}, {24'd0, exp});
    check({name, "_ser"},   {31'd0, b8.serialDataOut},   {31'd0, exp[0]});
    check({name, "_model"}, {24'd0, m8},                 {24'd0, exp});
  endtask

  task automatic lit16(input string name, input logic [15:0] exp);
    check({name, "_par"},   {16'd0, b16.parallelDataOut}, {16'd0, exp});
    check({name, "_ser"},   {31'd0, b16.serialDataOut},   {31'd0, exp[0]});
    check({name, "_model"}, {16'd0, m16},                 {16'd0, exp});
  endtask

  logic ser_bits [7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic a5_bits  [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    b8.parallelDataIn = '0;  b8.serialDataIn = 1'b0;
    b16.parallelDataIn = '0; b16.serialDataIn = 1'b0;
    idle_inputs();
    @(posedge clk); #1;

    s8(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    lit16("rst16", 16'h8001);
    for (int i = 0; i < 3; i++) begin
      s8(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      lit8("idle", 8'h00);
    end

    s8(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    lit8("first_bit", 8'h80);
    for (int i = 0; i < 7; i++) s8(1'b0, 1'b0, 1'b1, 8'h00, ser_bits[i]);
    lit8("deser55", 8'h55);

    s8(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    lit8("loadA5", 8'hA5);
    for (int i = 0; i < 8; i++) begin
      check("ser_seq", {31'd0, b8.serialDataOut}, {31'd0, a5_bits[i]});
      s8(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    end
    lit8("drained", 8'h00);

    s8(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    s8(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
    lit8("load_over_strobe", 8'h3C);

    s8(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    s8(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1);
    lit8("rst_over_all", 8'h00);
    s8(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    lit8("post_rst_shift", 8'h80);

    s8(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s8(1'b0, 1'b0, 1'b0, 8'h00, i[0]);
      lit8("hold", 8'hA5);
    end

    s16(1'b1, 1'b0, 16'hBEEF, 1'b0);
    lit16("loadBEEF", 16'hBEEF);
    s16(1'b0, 1'b1, 16'h0000, 1'b0);
    lit16("shift16a", 16'h5F77);
    s16(1'b0, 1'b1, 16'h0000, 1'b1);
    lit16("shift16b", 16'hAFBB);
    lit8("quiet8", 8'hA5);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
